// File: rtl/mux16_bus_arbiter.sv
// ============================================================================
// Module  : mux16_bus_arbiter
// Brief   : Two-requester round-robin arbiter feeding one registered 16-bit
//           output stage; ownership is held per burst, capped at MAX_BURST.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux16_bus_arbiter #(
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t              state_q;
  logic                prio_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;

  logic                slot_free;
  logic                xfer0;
  logic                xfer1;
  logic                xfer;
  logic                xfer_last;
  logic                release_burst;
  logic [DATA_W-1:0]   xfer_data;

  // The output slot can take a beat when empty or being drained this cycle.
  assign slot_free     = !out_valid_q || out_ready;
  assign req0_ready    = (state_q == OWN0) && slot_free;
  assign req1_ready    = (state_q == OWN1) && slot_free;
  assign xfer0         = req0_valid && req0_ready;
  assign xfer1         = req1_valid && req1_ready;
  assign xfer          = xfer0 || xfer1;
  assign xfer_data     = xfer1 ? req1_data : req0_data;
  assign xfer_last     = xfer1 ? req1_last : req0_last;
  assign release_burst = xfer && (xfer_last || (beat_cnt_q == CNT_LAST));

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = (state_q == OWN1);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (xfer) begin
        out_data_q  <= xfer_data;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (req0_valid && (!req1_valid || !prio_q)) begin
            state_q <= OWN0;
          end else if (req1_valid) begin
            state_q <= OWN1;
          end
        end
        OWN0, OWN1: begin
          // Priority passes to the other requester on every release.
          if (release_burst) begin
            state_q    <= IDLE;
            prio_q     <= (state_q == OWN0);
            beat_cnt_q <= '0;
          end else if (xfer) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux16_bus_arbiter.sv
// ============================================================================
// Module  : tb_mux16_bus_arbiter
// Brief   : Directed vector bench for mux16_bus_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux16_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_last, req0_ready;
  logic        req1_valid, req1_last, req1_ready;
  logic [15:0] req0_data, req1_data, out_data;
  logic        out_valid, out_ready, sel, busy;

  always #5 clk = ~clk;

  mux16_bus_arbiter #(.DATA_W(16), .MAX_BURST(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .sel        (sel),
    .busy       (busy)
  );

  typedef struct {
    logic        v0;
    logic [15:0] d0;
    logic        l0;
    logic        v1;
    logic [15:0] d1;
    logic        l1;
    logic        ordy;
    logic        r0;
    logic        r1;
    logic        ov;
    logic [15:0] od;
    logic        sel;
    logic        busy;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic v0, input logic [15:0] d0, input logic l0,
                              input logic v1, input logic [15:0] d1, input logic l1,
                              input logic ordy, input logic r0, input logic r1,
                              input logic ov, input logic [15:0] od,
                              input logic s, input logic b);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1;
    v.ordy = ordy; v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od;
    v.sel = s; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_data = v.d0; req0_last = v.l0;
    req1_valid = v.v1; req1_data = v.d1; req1_last = v.l1;
    out_ready  = v.ordy;
  endtask

  task automatic check_outs(input vec_t v, input string tag);
    chk($sformatf("%s req0_ready", tag), {15'b0, req0_ready}, {15'b0, v.r0});
    chk($sformatf("%s req1_ready", tag), {15'b0, req1_ready}, {15'b0, v.r1});
    chk($sformatf("%s out_valid", tag),  {15'b0, out_valid},  {15'b0, v.ov});
    chk($sformatf("%s out_data", tag),   out_data,            v.od);
    chk($sformatf("%s sel", tag),        {15'b0, sel},        {15'b0, v.sel});
    chk($sformatf("%s busy", tag),       {15'b0, busy},       {15'b0, v.busy});
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    check_outs(v, tag);
  endtask

  vec_t        tbl [26];
  vec_t        idle;
  logic [15:0] exp_beats [11];

  initial begin
    idle = mk(0, 16'h0, 0, 0, 16'h0, 0, 1, 0, 0, 0, 16'h0, 0, 0);

    // Contention with prio=0, then solo burst, then prio=1 contention, then backpressure.
    tbl[0]  = mk(1, 16'hA000, 0, 1, 16'hB000, 1, 1, 0, 0, 0, 16'h0000, 0, 0);
    tbl[1]  = mk(1, 16'hA000, 0, 1, 16'hB000, 1, 1, 1, 0, 0, 16'h0000, 0, 1);
    tbl[2]  = mk(1, 16'hA001, 1, 1, 16'hB000, 1, 1, 1, 0, 1, 16'hA000, 0, 1);
    tbl[3]  = mk(0, 16'h0000, 0, 1, 16'hB000, 1, 1, 0, 0, 1, 16'hA001, 0, 0);
    tbl[4]  = mk(0, 16'h0000, 0, 1, 16'hB000, 1, 1, 0, 1, 0, 16'hA001, 1, 1);
    tbl[5]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 1, 16'hB000, 0, 0);
    tbl[6]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 16'hB000, 0, 0);
    tbl[7]  = mk(1, 16'h1111, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 16'hB000, 0, 0);
    tbl[8]  = mk(1, 16'h1111, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 16'hB000, 0, 1);
    tbl[9]  = mk(1, 16'h2222, 0, 0, 16'h0000, 0, 1, 1, 0, 1, 16'h1111, 0, 1);
    tbl[10] = mk(1, 16'h3333, 1, 0, 16'h0000, 0, 1, 1, 0, 1, 16'h2222, 0, 1);
    tbl[11] = mk(1, 16'hC000, 1, 1, 16'hD000, 1, 1, 0, 0, 1, 16'h3333, 0, 0);
    tbl[12] = mk(1, 16'hC000, 1, 1, 16'hD000, 1, 1, 0, 1, 0, 16'h3333, 1, 1);
    tbl[13] = mk(1, 16'hC000, 1, 0, 16'h0000, 0, 1, 0, 0, 1, 16'hD000, 0, 0);
    tbl[14] = mk(1, 16'hC000, 1, 0, 16'h0000, 0, 1, 1, 0, 0, 16'hD000, 0, 1);
    tbl[15] = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 1, 16'hC000, 0, 0);
    tbl[16] = mk(0, 16'h0000, 0, 1, 16'hE001, 0, 1, 0, 0, 0, 16'hC000, 0, 0);
    tbl[17] = mk(0, 16'h0000, 0, 1, 16'hE001, 0, 1, 0, 1, 0, 16'hC000, 1, 1);
    tbl[18] = mk(0, 16'h0000, 0, 1, 16'hE002, 0, 1, 0, 1, 1, 16'hE001, 1, 1);
    tbl[19] = mk(0, 16'h0000, 0, 1, 16'hE003, 0, 0, 0, 0, 1, 16'hE002, 1, 1);
    tbl[20] = mk(0, 16'h0000, 0, 1, 16'hE003, 0, 0, 0, 0, 1, 16'hE002, 1, 1);
    tbl[21] = mk(0, 16'h0000, 0, 1, 16'hE003, 0, 0, 0, 0, 1, 16'hE002, 1, 1);
    tbl[22] = mk(0, 16'h0000, 0, 1, 16'hE003, 0, 1, 0, 1, 1, 16'hE002, 1, 1);
    tbl[23] = mk(0, 16'h0000, 0, 1, 16'hE004, 1, 1, 0, 1, 1, 16'hE003, 1, 1);
    tbl[24] = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 1, 16'hE004, 0, 0);
    tbl[25] = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 16'hE004, 0, 0);

    for (int i = 0; i < 8; i++) exp_beats[i] = 16'hF000 + 16'(i);
    exp_beats[8]  = 16'h5000;
    exp_beats[9]  = 16'hF008;
    exp_beats[10] = 16'hF009;

    // Reset held with every requester asserting valid.
    rst_n = 1'b0;
    drive(idle);
    for (int i = 0; i < 3; i++)
      apply(mk(1, 16'h1234, 1, 1, 16'h5678, 1, 1, 0, 0, 0, 16'h0, 0, 0), "T1 reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle);

    for (int i = 0; i < 26; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Forced release: req1 streams 10 beats with req0 waiting from cycle 1.
    begin
      int i1  = 0;
      int got = 0;
      int cyc = 0;
      bit s0  = 1'b0;
      while (got < 11 && cyc < 60) begin
        @(negedge clk);
        req1_valid = (i1 < 10);
        req1_data  = 16'hF000 + 16'(i1);
        req1_last  = (i1 == 9);
        req0_valid = (cyc >= 1) && !s0;
        req0_data  = 16'h5000;
        req0_last  = 1'b1;
        out_ready  = 1'b1;
        #1;
        if (out_valid) begin
          chk($sformatf("T4 beat%0d", got), out_data, exp_beats[got]);
          got++;
        end
        if (req1_valid && req1_ready) i1++;
        if (req0_valid && req0_ready) s0 = 1'b1;
        cyc++;
      end
      if (got < 11) begin
        n_chk++;
        n_fail++;
        $display("FAIL T4 timeout: got %0d beats, expected 11", got);
      end
    end

    // Asynchronous reset after the second beat of a 4-beat burst.
    apply(mk(1, 16'h6001, 0, 0, 16'h0, 0, 1, 0, 0, 0, 16'hF009, 0, 0), "T6 idle");
    apply(mk(1, 16'h6001, 0, 0, 16'h0, 0, 1, 1, 0, 0, 16'hF009, 0, 1), "T6 grant");
    apply(mk(1, 16'h6002, 0, 0, 16'h0, 0, 1, 1, 0, 1, 16'h6001, 0, 1), "T6 beat2");
    @(negedge clk);
    drive(mk(1, 16'h6003, 0, 1, 16'h7000, 1, 1, 0, 0, 0, 16'h0, 0, 0));
    #1;
    rst_n = 1'b0;
    #1;
    check_outs(mk(1, 16'h6003, 0, 1, 16'h7000, 1, 1, 0, 0, 0, 16'h0, 0, 0), "T6 async");
    apply(mk(1, 16'h6003, 0, 1, 16'h7000, 1, 1, 0, 0, 0, 16'h0, 0, 0), "T6 held");
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1, 16'h8000, 1, 1, 16'h7000, 1, 1, 0, 0, 0, 16'h0, 0, 0));
    apply(mk(1, 16'h8000, 1, 1, 16'h7000, 1, 1, 1, 0, 0, 16'h0000, 0, 1), "T6 own0");
    apply(mk(0, 16'h0000, 0, 1, 16'h7000, 1, 1, 0, 0, 1, 16'h8000, 0, 0), "T6 idle2");
    apply(mk(0, 16'h0000, 0, 1, 16'h7000, 1, 1, 0, 1, 0, 16'h8000, 1, 1), "T6 own1");
    apply(idle.v0 ? idle : mk(0, 16'h0, 0, 0, 16'h0, 0, 1, 0, 0, 1, 16'h7000, 0, 0), "T6 out");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
